// File: rtl/pb_event_fifo_if.sv
// Read-bus interface between the CPU and the push-button event FIFO.
//   addr : CPU read address
//   rd   : one-cycle read strobe, qualified by addr
//   out  : read data returned by the FIFO block
//   irq  : high while events are pending in the FIFO
// The master modport is the CPU side. The slave modport is the FIFO side.
interface pb_event_fifo_if;
    logic [7:0] addr;
    logic       rd;
    logic [7:0] out;
    logic       irq;

    modport master (output addr, output rd, input out, input irq);
    modport slave  (input addr, input rd, output out, output irq);
endinterface

// File: rtl/pb_event_fifo.sv
// pb_event_fifo
//   Turns every 0->1 transition of the debounced button levels into a one-byte event code
//   {1'b1,4'b0,index}. It queues the code in a DEPTH-entry FIFO, which the CPU reads over an
//   8-bit memory-mapped read bus.
//   A pending bit is kept for each button. One event is serviced per cycle, and the lowest
//   index goes first. A rise on a bit that is already pending merges with that pending event.
//   When the FIFO is full and nothing pops in the same cycle, the event is dropped and the
//   sticky ovf flag is set.
//
// Optional feature (compile-time macro PB_RELEASE_EVT_EN):
//   When the macro is defined, 1->0 transitions are also queued, with codes {1'b0,4'b0,index}.
//   Release events have their own pending register. All pending presses are serviced before
//   any release.
//
// Ports
//   clk    : system clock; all state changes on posedge
//   rst_n  : asynchronous active-low reset
//   state  : 5 debounced button levels; bit i is button i
//   bus    : read-bus slave (addr, rd in; out, irq out)
//     reading DATA_ADDR returns the head event, and a read with rd pops it (8'h00 when empty)
//     reading STAT_ADDR returns {ovf, full, empty, 1'b0, count[3:0]}, and a read with rd clears ovf
//     reading any other address returns 8'h00
//     irq is high whenever the FIFO is not empty
module pb_event_fifo #(
    parameter int          DEPTH     = 8,
    parameter logic [7:0]  DATA_ADDR = 8'hfc,
    parameter logic [7:0]  STAT_ADDR = 8'hfd
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      state,
    pb_event_fifo_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Isolate the lowest set bit of a vector (two's-complement trick).
    function automatic logic [4:0] lowest_bit(input logic [4:0] v);
        return v & (~v + 5'd1);
    endfunction

    // Convert a one-hot (or zero) 5-bit vector into its index.
    function automatic logic [2:0] onehot_index(input logic [4:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    logic [4:0]    prev_state;
    logic [4:0]    press_pend;
    logic [4:0]    press_rise;
    logic [4:0]    press_served;
`ifdef PB_RELEASE_EVT_EN
    logic [4:0]    rel_pend;
    logic [4:0]    rel_rise;
    logic [4:0]    rel_served;
`endif

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [3:0]    count_lo;
    logic          ovf;

    logic          empty;
    logic          full;
    logic          pop;
    logic          stat_rd;
    logic          svc_valid;
    logic [7:0]    svc_code;
    logic          push;
    logic          drop;

    // Edge detection and service selection.
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        press_rise   = state & ~prev_state;
        press_served = lowest_bit(press_pend);
`ifdef PB_RELEASE_EVT_EN
        rel_rise     = ~state & prev_state;
        // Releases are serviced only when no press is waiting.
        rel_served   = (press_pend == 5'd0) ? lowest_bit(rel_pend) : 5'd0;
        svc_valid    = (press_pend != 5'd0) || (rel_pend != 5'd0);
        svc_code     = (press_pend != 5'd0) ? {1'b1, 4'b0000, onehot_index(press_served)}
                                            : {1'b0, 4'b0000, onehot_index(rel_served)};
`else
        svc_valid    = (press_pend != 5'd0);
        svc_code     = {1'b1, 4'b0000, onehot_index(press_served)};
`endif
    end

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign count_lo = 4'(count);
    assign pop      = bus.rd && (bus.addr == DATA_ADDR) && !empty;
    assign stat_rd  = bus.rd && (bus.addr == STAT_ADDR);
    // A full FIFO can still accept an event when a pop frees a slot in the same cycle.
    assign push     = svc_valid && (!full || pop);
    assign drop     = svc_valid && full && !pop;

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_state <= 5'd0;
            press_pend <= 5'd0;
`ifdef PB_RELEASE_EVT_EN
            rel_pend   <= 5'd0;
`endif
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovf        <= 1'b0;
        end else begin
            prev_state <= state;
            // The served bit is cleared whether the event was pushed or dropped.
            press_pend <= (press_pend & ~press_served) | press_rise;
`ifdef PB_RELEASE_EVT_EN
            rel_pend   <= (rel_pend & ~rel_served) | rel_rise;
`endif
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // If an overflow happens in the same cycle as a status read, ovf stays set.
            if (drop)         ovf <= 1'b1;
            else if (stat_rd) ovf <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset. The pointers and count make stale entries unreachable,
    // so the array can map to plain RAM or flops without reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= svc_code;
    end

    // The read mux is combinational from the registers and addr.
    always_comb begin
        bus.out = 8'h00;
        if (bus.addr == DATA_ADDR) begin
            if (!empty) bus.out = mem[rd_ptr];
        end else if (bus.addr == STAT_ADDR) begin
            bus.out = {ovf, full, empty, 1'b0, count_lo};
        end
    end

    assign bus.irq = ~empty;

endmodule

// File: tb/tb_pb_event_fifo.sv
// Self-checking bench for pb_event_fifo.
// A queue-based reference model runs beside the DUT. It checks out and irq on every cycle.
// Directed checks cover the documented scenarios, and a randomized phase with one async reset follows.
module tb_pb_event_fifo;

    localparam int         DEPTH  = 8;
    localparam logic [7:0] DATA_A = 8'hfc;
    localparam logic [7:0] STAT_A = 8'hfd;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] state = 5'd0;

    pb_event_fifo_if bus ();

    pb_event_fifo #(
        .DEPTH     (DEPTH),
        .DATA_ADDR (DATA_A),
        .STAT_ADDR (STAT_A)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .state (state),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    string      phase = "init";
    logic [7:0] last_out;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %02h expected %02h at %0t", phase, tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];
    bit         m_press [5];
    bit         m_rel   [5];
    bit         m_prev  [5];
    bit         m_ovf;

    task automatic m_reset();
        m_q.delete();
        for (int i = 0; i < 5; i++) begin
            m_press[i] = 0;
            m_rel[i]   = 0;
            m_prev[i]  = 0;
        end
        m_ovf = 0;
    endtask

    function automatic logic [7:0] m_out(input logic [7:0] a);
        int n;
        n = m_q.size();
        if (a == DATA_A) return (n > 0) ? m_q[0] : 8'h00;
        if (a == STAT_A) return {m_ovf, (n == DEPTH), (n == 0), 1'b0, 4'(n)};
        return 8'h00;
    endfunction

    // Advance the model by one clock edge, using the inputs that were applied during the cycle.
    task automatic m_clock(input logic [4:0] st, input logic [7:0] a, input logic r);
        bit pop;
        bit was_full;
        bit is_press;
        int sel;
        pop      = r && (a == DATA_A) && (m_q.size() > 0);
        was_full = (m_q.size() == DEPTH);
        sel      = -1;
        is_press = 0;
        for (int i = 0; i < 5; i++)
            if (m_press[i] && sel < 0) begin sel = i; is_press = 1; end
`ifdef PB_RELEASE_EVT_EN
        if (sel < 0)
            for (int i = 0; i < 5; i++)
                if (m_rel[i] && sel < 0) sel = i;
`endif
        if (pop) void'(m_q.pop_front());
        if (r && a == STAT_A) m_ovf = 0;
        if (sel >= 0) begin
            if (!was_full || pop) m_q.push_back(is_press ? (8'h80 + 8'(sel)) : 8'(sel));
            else                  m_ovf = 1;
            if (is_press) m_press[sel] = 0;
            else          m_rel[sel]   = 0;
        end
        for (int i = 0; i < 5; i++) begin
            if (st[i] && !m_prev[i]) m_press[i] = 1;
`ifdef PB_RELEASE_EVT_EN
            if (!st[i] && m_prev[i]) m_rel[i] = 1;
`endif
            m_prev[i] = st[i];
        end
    endtask

    // One bus cycle: drive on the falling edge, check 1 ns later, then clock the model on the rising edge.
    task automatic cycle(input logic [4:0] st, input logic [7:0] a, input logic r);
        @(negedge clk);
        state    = st;
        bus.addr = a;
        bus.rd   = r;
        #1;
        last_out = bus.out;
        check("out", bus.out, m_out(a));
        check("irq", {7'd0, bus.irq}, {7'd0, (m_q.size() != 0)});
        @(posedge clk);
        m_clock(st, a, r);
    endtask

    // Pulse the asynchronous reset in the middle of a cycle. The outputs must clear at once.
    task automatic async_reset();
        @(negedge clk);
        state    = 5'd0;
        bus.addr = STAT_A;
        bus.rd   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_irq", {7'd0, bus.irq}, 8'h00);
        check("rst_stat", bus.out, 8'h20);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        m_clock(state, bus.addr, bus.rd);
    endtask

    initial begin
        logic [4:0] st;
        logic [7:0] a;
        logic       r;
        int         sel;

        bus.addr = 8'h00;
        bus.rd   = 1'b0;
        m_reset();

        // 1: reset state
        phase = "reset";
        #1;
        check("irq_in_rst", {7'd0, bus.irq}, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        m_clock(5'd0, 8'h00, 1'b0);
        cycle(5'd0, STAT_A, 1'b0); check("stat_empty", last_out, 8'h20);
        cycle(5'd0, DATA_A, 1'b0); check("data_empty", last_out, 8'h00);

        // 2: single press of button 2
        phase = "single";
        cycle(5'b00100, 8'h00, 1'b0);
        cycle(5'b00100, 8'h00, 1'b0);
        cycle(5'b00100, STAT_A, 1'b0); check("stat_one", last_out, 8'h01);
        cycle(5'b00100, DATA_A, 1'b1); check("pop_b2", last_out, 8'h82);
        cycle(5'b00100, STAT_A, 1'b0); check("stat_after", last_out, 8'h20);

        // 3: simultaneous rises are serviced lowest index first
        phase = "simul";
        cycle(5'b00000, 8'h00, 1'b0);
        repeat (5) cycle(5'b10011, 8'h00, 1'b0);
        cycle(5'b10011, DATA_A, 1'b1); check("pop0", last_out, 8'h80);
        cycle(5'b10011, DATA_A, 1'b1); check("pop1", last_out, 8'h81);
        cycle(5'b10011, DATA_A, 1'b1); check("pop4", last_out, 8'h84);

        // 4: overflow with nine presses and no reads
        phase = "ovf";
        repeat (2) cycle(5'd0, 8'h00, 1'b0);
        repeat (9) begin
            cycle(5'b00001, 8'h00, 1'b0);
            cycle(5'b00000, 8'h00, 1'b0);
        end
        repeat (2) cycle(5'd0, 8'h00, 1'b0);
        cycle(5'd0, STAT_A, 1'b1); check("stat_ovf", last_out, 8'hc8);
        cycle(5'd0, STAT_A, 1'b0); check("stat_clr", last_out, 8'h48);
        for (int k = 0; k < 8; k++) begin
            cycle(5'd0, DATA_A, 1'b1); check("drain", last_out, 8'h80);
        end

        // 5: push and pop in the same cycle while the FIFO is full
        phase = "full_pp";
        repeat (8) begin
            cycle(5'b00001, 8'h00, 1'b0);
            cycle(5'b00000, 8'h00, 1'b0);
        end
        repeat (2) cycle(5'd0, 8'h00, 1'b0);
        cycle(5'd0, STAT_A, 1'b0); check("stat_full", last_out, 8'h48);
        cycle(5'b01000, 8'h00, 1'b0);
        cycle(5'b01000, DATA_A, 1'b1); check("pp_pop", last_out, 8'h80);
        cycle(5'b01000, STAT_A, 1'b0); check("pp_stat", last_out, 8'h48);
        for (int k = 0; k < 7; k++) cycle(5'b01000, DATA_A, 1'b1);
        cycle(5'b01000, DATA_A, 1'b1); check("pp_last", last_out, 8'h83);

        // 6: async reset with three events queued
        phase = "areset";
        cycle(5'd0, 8'h00, 1'b0);
        repeat (4) cycle(5'b00111, 8'h00, 1'b0);
        cycle(5'b00111, STAT_A, 1'b0); check("stat_three", last_out, 8'h03);
        async_reset();
        cycle(5'd0, STAT_A, 1'b0); check("stat_post", last_out, 8'h20);
`ifdef PB_RELEASE_EVT_EN
        phase = "release";
        repeat (3) cycle(5'b00010, 8'h00, 1'b0);
        repeat (3) cycle(5'b00000, 8'h00, 1'b0);
        cycle(5'd0, DATA_A, 1'b1); check("rel_press", last_out, 8'h81);
        cycle(5'd0, DATA_A, 1'b1); check("rel_rel", last_out, 8'h01);
`endif

        // Randomized traffic checked cycle by cycle against the model.
        phase = "random";
        st = 5'd0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0) st = 5'($urandom_range(31));
            r   = 1'($urandom_range(1));
            sel = $urandom_range(9);
            if (sel < 5)      a = DATA_A;
            else if (sel < 8) a = STAT_A;
            else              a = 8'($urandom_range(255));
            if (c == 700) async_reset();
            cycle(st, a, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
